// File: rtl/ysyx_22040127_div.sv
// Iterative radix-2 restoring divider for the RV64M execute stage.
// Covers DIV/DIVU/REM/REMU and the W forms; one result pair every 66 cycles.
module ysyx_22040127_div #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [XLEN-1:0]  rem_r;
    logic [XLEN-1:0]  quo_r;
    logic [XLEN-1:0]  abs_y_r;
    logic [XLEN-1:0]  x_ext_r;
    logic             sx_r;
    logic             sy_r;
    logic             word_r;
    logic             div_zero_r;

    logic [XLEN-1:0]  x_ext;
    logic [XLEN-1:0]  y_ext;
    logic             x_neg;
    logic             y_neg;
    logic [XLEN-1:0]  abs_x;
    logic [XLEN-1:0]  abs_y;

    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;

    logic [XLEN-1:0]  q_signed;
    logic [XLEN-1:0]  r_signed;
    logic [XLEN-1:0]  q_res;
    logic [XLEN-1:0]  r_res;

    assign div_ready = (state == IDLE);

    // Operand conditioning at accept: narrow W operands, then split into sign and magnitude.
    always_comb begin
        x_ext = dividend;
        y_ext = divisor;
        if (div_word) begin
            if (div_signed) begin
                x_ext = {{(XLEN-32){dividend[31]}}, dividend[31:0]};
                y_ext = {{(XLEN-32){divisor[31]}}, divisor[31:0]};
            end else begin
                x_ext = {{(XLEN-32){1'b0}}, dividend[31:0]};
                y_ext = {{(XLEN-32){1'b0}}, divisor[31:0]};
            end
        end
        x_neg = div_signed & x_ext[XLEN-1];
        y_neg = div_signed & y_ext[XLEN-1];
        abs_x = x_neg ? -x_ext : x_ext;
        abs_y = y_neg ? -y_ext : y_ext;
    end

    // One restoring step; the 65-bit trial keeps a 2^63 divisor magnitude exact.
    always_comb begin
        shifted = {rem_r, quo_r[XLEN-1]};
        trial   = shifted - {1'b0, abs_y_r};
    end

    always_comb begin
        q_signed = (sx_r ^ sy_r) ? -quo_r : quo_r;
        r_signed = sx_r ? -rem_r : rem_r;
        q_res    = q_signed;
        r_res    = r_signed;
        if (word_r) begin
            q_res = {{(XLEN-32){q_signed[31]}}, q_signed[31:0]};
            r_res = {{(XLEN-32){r_signed[31]}}, r_signed[31:0]};
        end
        if (div_zero_r) begin
            q_res = '1;
            r_res = word_r ? {{(XLEN-32){x_ext_r[31]}}, x_ext_r[31:0]} : x_ext_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            out_valid  <= 1'b0;
            quotient   <= '0;
            remainder  <= '0;
            rem_r      <= '0;
            quo_r      <= '0;
            abs_y_r    <= '0;
            x_ext_r    <= '0;
            sx_r       <= 1'b0;
            sy_r       <= 1'b0;
            word_r     <= 1'b0;
            div_zero_r <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (div_valid && !flush) begin
                        state      <= CALC;
                        counter    <= '0;
                        rem_r      <= '0;
                        quo_r      <= abs_x;
                        abs_y_r    <= abs_y;
                        x_ext_r    <= x_ext;
                        sx_r       <= x_neg;
                        sy_r       <= y_neg;
                        word_r     <= div_word;
                        div_zero_r <= (y_ext == '0);
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (!trial[XLEN]) begin
                            rem_r <= trial[XLEN-1:0];
                            quo_r <= {quo_r[XLEN-2:0], 1'b1};
                        end else begin
                            rem_r <= shifted[XLEN-1:0];
                            quo_r <= {quo_r[XLEN-2:0], 1'b0};
                        end
                        counter <= counter + 1'b1;
                        if (counter == CNT_W'(XLEN-1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (!flush) begin
                        out_valid <= 1'b1;
                        quotient  <= q_res;
                        remainder <= r_res;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040127_div.sv
// Scoreboard bench for ysyx_22040127_div: directed vectors with hand-computed results,
// plus latency, single-pulse, div_ready, flush and mid-operation reset checks.
module tb_ysyx_22040127_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        div_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_signed;
    logic        div_word;
    logic        flush;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_start = 0;
    int   busy_end = -1;
    logic prev_ov = 1'b0;

    ysyx_22040127_div #(.XLEN(64), .CNT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_signed (div_signed),
        .div_word   (div_word),
        .flush      (flush),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every result pulse and tracks div_ready against the busy window.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("div_ready", {63'b0, div_ready},
                        {63'b0, !(cyc >= busy_start && cyc <= busy_end)});
        end
        if (out_valid) begin
            checkOutput("single_pulse", {63'b0, prev_ov}, 64'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("latency", 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result_timeout", 64'(cyc), 64'(e.due));
        end
        prev_ov = out_valid;
    end

    task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y, input logic sgn,
                                 input logic word, input logic expect_result,
                                 input logic [63:0] q, input logic [63:0] r);
        int waited;
        exp_t e;
        @(negedge clk);
        dividend   = x;
        divisor    = y;
        div_signed = sgn;
        div_word   = word;
        div_valid  = 1'b1;
        waited = 0;
        while (!div_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!div_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            div_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        busy_start = cyc;
        busy_end   = cyc + 64;
        if (expect_result) begin
            e.q   = q;
            e.r   = r;
            e.due = cyc + 65;
            sb.push_back(e);
        end
    endtask

    initial begin
        int waited;
        rst        = 1'b1;
        div_valid  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_signed = 1'b0;
        div_word   = 1'b0;
        flush      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_quotient", quotient, 64'd0);
        checkOutput("reset_remainder", remainder, 64'd0);
        checkOutput("reset_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("reset_ready", {63'b0, div_ready}, 64'd1);
        rst = 1'b0;

        // Requests are issued back to back, each one held until the divider is idle again.
        applyStimulus(64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd14, 64'd2);
        applyStimulus(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(64'd7, -64'sd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1);
        applyStimulus(64'd5, 64'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5);
        applyStimulus(64'h1_8000_0000, 64'd0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1,
                      64'h8000_0000_0000_0000, 64'd0);
        applyStimulus(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd0);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        applyStimulus(64'hFFFF_FFFF, 64'd2, 1'b0, 1'b1, 1'b1, 64'h7FFF_FFFF, 64'd1);
        applyStimulus(64'h1234_0000_FFFF_FFFE, 64'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(64'h8000_0001, 64'd0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001);
        applyStimulus(-64'sd100, -64'sd7, 1'b1, 1'b0, 1'b1, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(64'd0, 64'd5, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
        applyStimulus(64'd3, 64'd5, 1'b0, 1'b0, 1'b1, 64'd0, 64'd3);
        applyStimulus(64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0, 1'b1, 64'hC000_0000_0000_0000, 64'd0);

        // Abort mid-CALC with flush: no result, previous result registers untouched.
        applyStimulus(64'd50, 64'd5, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (30) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        busy_end = cyc - 1;
        @(negedge clk);
        checkOutput("flush_ready", {63'b0, div_ready}, 64'd1);
        checkOutput("flush_keeps_quotient", quotient, 64'hC000_0000_0000_0000);
        applyStimulus(64'd9, 64'd3, 1'b0, 1'b0, 1'b1, 64'd3, 64'd0);

        // Abort mid-CALC with reset: outputs return to their reset values.
        applyStimulus(64'd77, 64'd4, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        busy_end = cyc - 1;
        @(negedge clk);
        checkOutput("rst_quotient", quotient, 64'd0);
        checkOutput("rst_remainder", remainder, 64'd0);
        checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_ready", {63'b0, div_ready}, 64'd1);
        rst = 1'b0;
        applyStimulus(64'd1, 64'd1, 1'b0, 1'b0, 1'b1, 64'd1, 64'd0);

        waited = 0;
        while (sb.size() > 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("hold_quotient", quotient, 64'd1);
        checkOutput("hold_remainder", remainder, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040127_div.md
Name: ysyx_22040127_div

Overview:
- Iterative radix-2 restoring divider for the RV64M execute stage.
- Inverse counterpart of the pipelined Booth/Wallace multiplier; shares the same EXU operand and result buses.
- Covers DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Accepts one operation at a time and returns quotient and remainder together after a fixed latency.

Parameters:
- XLEN, 64: operand and result width.
- CNT_W, 7: iteration counter width; must hold the value XLEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- div_valid  in  1  request strobe.
- div_ready  out  1  divider idle and able to accept a request.
- dividend  in  XLEN  x operand.
- divisor  in  XLEN  y operand.
- div_signed  in  1  1 = signed (DIV/REM), 0 = unsigned.
- div_word  in  1  1 = 32-bit W variant.
- flush  in  1  abort the operation in flight (pipeline redirect).
- out_valid  out  1  one-cycle pulse: results valid.
- quotient  out  XLEN  registered quotient.
- remainder  out  XLEN  registered remainder.

Behaviour:
- Reset: state=IDLE, counter=0, out_valid=0, quotient=0, remainder=0, div_ready=1.
- States: IDLE -> CALC -> DONE -> IDLE.
- div_ready=1 only in IDLE.

Accept:
- A request is accepted when div_valid & div_ready are both high at a rising edge.
- Operand preprocessing at acceptance:
  - W forms take x[31:0]/y[31:0]; signed ops sign-extend them to 64 bits, unsigned ops zero-extend them.
  - Signed ops latch sx = x[63] and sy = y[63], then take absolute values. Treat |-2^63| as the unsigned value 2^63.
  - Unsigned ops latch sx = sy = 0.
  - Latch div_zero = (extended y == 0) and the original extended x.
- The accept cycle moves to CALC with counter=0 and the partial remainder cleared.

CALC:
- One iteration per cycle, 64 cycles total.
- Each iteration: shift {rem, quo} left 1. If the upper 65-bit trial difference rem - |y| is non-negative, replace rem and set the quotient LSB to 1.
- Exit to DONE after the iteration with counter=63.

DONE (one cycle):
- out_valid=1.
- quotient = sx^sy ? -quo : quo.
- remainder = sx ? -rem : rem.
- W forms: both results are sign-extended from bit 31 of the above.
- div_zero overrides the computed results: quotient = all ones, remainder = extended x (W: sext of x[31:0]).
- Next cycle returns to IDLE with out_valid=0.

Outputs and latency:
- quotient/remainder hold their values until the next DONE and are not cleared on accept.
- Accepted at edge T: out_valid is high in the cycle after edge T+65. That gives 66 cycles from accept to result, and a new request can be accepted the cycle after DONE.
- Results need no backpressure; the consumer must sample them in the out_valid cycle.

Overflow:
- -2^63 / -1 (signed, 64-bit) yields quotient 0x8000_0000_0000_0000 and remainder 0, as the natural result of the magnitude path.
- DIVW -2^31 / -1 yields 0xFFFF_FFFF_8000_0000 and remainder 0.

Flush and reset:
- flush high in CALC or DONE forces IDLE on the next edge, suppresses out_valid, and leaves the result registers unchanged.
- flush in IDLE has no effect; a request presented with flush is not accepted (flush wins).
- rst has priority over flush and any request, at any state, including mid-CALC. The state returns to IDLE and outputs take their reset values.

Test Plan:
- DIVU 100/7 -> quotient=14, remainder=2; out_valid exactly 66 cycles after accept, single-cycle pulse; div_ready low throughout.
- DIV -7/2 -> quotient=-3 (0xFFFF_FFFF_FFFF_FFFD), remainder=-1. REM 7/-2 -> remainder=1, quotient=-3.
- Divide by zero: DIVU 5/0 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5. DIVW x=0x1_8000_0000, y=0 -> remainder=0xFFFF_FFFF_8000_0000.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 -> quotient=0x8000_0000_0000_0000, remainder=0. DIVW 0x8000_0000 / 0xFFFF_FFFF -> quotient=0xFFFF_FFFF_8000_0000, remainder=0.
- Abort: flush at cycle 30 of CALC -> no out_valid pulse, div_ready=1 next cycle, a fresh DIVU 9/3 then returns quotient=3 after 66 cycles. Repeat with rst mid-CALC -> all outputs 0.
- Back-to-back: issue a request the cycle after DONE -> accepted, correct result. A request held during CALC is not accepted until IDLE. Random signed/unsigned/W operands are checked against the reference model over 10k ops.
